// File: rtl/core_pkg.sv
// Shared definitions for the RV32I multi-cycle core: opcode constants
// used by both the decoder and the sequencer, the sequencer state
// encoding, the write-back mux encodings and the default reset vector.
package core_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    localparam int STATE_W = 3;

    // insn[6:2] major opcodes
    localparam logic [4:0] OPC_LUI    = 5'b01101;
    localparam logic [4:0] OPC_AUIPC  = 5'b00101;
    localparam logic [4:0] OPC_JAL    = 5'b11011;
    localparam logic [4:0] OPC_JALR   = 5'b11001;
    localparam logic [4:0] OPC_BRANCH = 5'b11000;
    localparam logic [4:0] OPC_LOAD   = 5'b00000;
    localparam logic [4:0] OPC_STORE  = 5'b01000;
    localparam logic [4:0] OPC_OP     = 5'b01100;
    localparam logic [4:0] OPC_OPIMM  = 5'b00100;
    localparam logic [4:0] OPC_FENCE  = 5'b00011;

    // Register file write-back source select
    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;
    localparam logic [1:0] WB_IMM = 2'd3;

    typedef enum logic [STATE_W-1:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        TRAP   = 3'd5
    } state_t;

    // True for every opcode the core knows how to sequence
    function automatic logic is_supported(input logic [4:0] op);
        case (op)
            OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH,
            OPC_LOAD, OPC_STORE, OPC_OP, OPC_OPIMM, OPC_FENCE: is_supported = 1'b1;
            default:                                           is_supported = 1'b0;
        endcase
    endfunction

    // True for opcodes that write a destination register in WB
    function automatic logic writes_rd(input logic [4:0] op);
        case (op)
            OPC_LUI, OPC_AUIPC, OPC_OP, OPC_OPIMM,
            OPC_LOAD, OPC_JAL, OPC_JALR:           writes_rd = 1'b1;
            default:                               writes_rd = 1'b0;
        endcase
    endfunction

    // Source of the register write-back value for a given opcode
    function automatic logic [1:0] wb_sel_of(input logic [4:0] op);
        case (op)
            OPC_LUI:            wb_sel_of = WB_IMM;
            OPC_LOAD:           wb_sel_of = WB_MEM;
            OPC_JAL, OPC_JALR:  wb_sel_of = WB_PC4;
            default:            wb_sel_of = WB_ALU;
        endcase
    endfunction

endpackage

// File: rtl/core_ctrl_if.sv
// Bundle of the sequencer's connections to the decoder, ALU/comparator,
// memory port and register file. The master side is the sequencer; the
// slave side is the surrounding datapath.
interface core_ctrl_if;
    import core_pkg::*;

    logic [4:0]         opcode;
    logic               invalid;
    logic [31:0]        imm;
    logic [31:0]        alu_res;
    logic               br_taken;
    logic               mem_ready;

    logic               mem_req;
    logic               mem_we;
    logic               mem_addr_sel;
    logic               ir_we;
    logic               alu_a_sel;
    logic               alu_b_sel;
    logic               reg_we;
    logic [1:0]         wb_sel;
    logic [31:0]        pc;
    logic               retire;
    logic               trap;
    logic [STATE_W-1:0] state;

    modport master (
        input  opcode, invalid, imm, alu_res, br_taken, mem_ready,
        output mem_req, mem_we, mem_addr_sel, ir_we, alu_a_sel, alu_b_sel,
               reg_we, wb_sel, pc, retire, trap, state
    );

    modport slave (
        output opcode, invalid, imm, alu_res, br_taken, mem_ready,
        input  mem_req, mem_we, mem_addr_sel, ir_we, alu_a_sel, alu_b_sel,
               reg_we, wb_sel, pc, retire, trap, state
    );

endinterface

// File: rtl/core_ctrl_pc_next.sv
// Next program counter selection for the sequencer, plus a flag raised
// when a jump or taken branch would land on a non-word-aligned address.
module pc_next
    import core_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [31:0] imm,
    input  logic [31:0] alu_res,
    input  logic [4:0]  opcode,
    input  logic        br_taken,
    output logic [31:0] next_pc,
    output logic        misaligned
);

    logic [31:0] pc_plus4;
    logic [31:0] pc_plus_imm;
    logic [31:0] jalr_tgt;
    logic        redirect;

    assign pc_plus4    = pc + 32'd4;
    assign pc_plus_imm = pc + imm;
    assign jalr_tgt    = alu_res & 32'hFFFF_FFFE;

    // Choose the follow-on address; only redirected flow can be misaligned
    always_comb begin
        next_pc  = pc_plus4;
        redirect = 1'b0;
        case (opcode)
            OPC_JAL: begin
                next_pc  = pc_plus_imm;
                redirect = 1'b1;
            end
            OPC_JALR: begin
                next_pc  = jalr_tgt;
                redirect = 1'b1;
            end
            OPC_BRANCH: begin
                if (br_taken) begin
                    next_pc  = pc_plus_imm;
                    redirect = 1'b1;
                end
            end
            default: begin
                next_pc  = pc_plus4;
                redirect = 1'b0;
            end
        endcase
        misaligned = redirect & next_pc[1];
    end

endmodule

// File: rtl/core_ctrl.sv
// Multi-cycle sequencer for the RV32I core. Holds the program counter and
// steps each instruction through FETCH, DECODE, EXEC, MEM and WB, driving
// the datapath enables and mux selects. Unsupported instructions and
// misaligned control transfers halt the core in TRAP until reset.
module core_ctrl
    import core_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
)
(
    input  logic       clk,
    input  logic       rst_n,
    core_ctrl_if.master bus
);

    state_t      state_q;
    state_t      state_d;
    logic [31:0] pc_q;
    logic [31:0] next_pc;
    logic        misaligned;
    logic        pc_we;

    logic        is_ld;
    logic        is_st;

    logic        mem_req;
    logic        mem_we;
    logic        mem_addr_sel;
    logic        ir_we;
    logic        alu_a_sel;
    logic        alu_b_sel;
    logic        reg_we;
    logic [1:0]  wb_sel;
    logic        retire;
    logic        trap;

    assign is_ld = (bus.opcode == OPC_LOAD);
    assign is_st = (bus.opcode == OPC_STORE);

    pc_next u_pc_next (
        .pc         (pc_q),
        .imm        (bus.imm),
        .alu_res    (bus.alu_res),
        .opcode     (bus.opcode),
        .br_taken   (bus.br_taken),
        .next_pc    (next_pc),
        .misaligned (misaligned)
    );

    // State register; reset restarts fetching from the reset vector
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Program counter advances only when an instruction retires
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else if (pc_we) begin
            pc_q <= next_pc;
        end
    end

    // Next-state and control decode from the current state and latched opcode
    always_comb begin
        state_d      = state_q;
        pc_we        = 1'b0;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        ir_we        = 1'b0;
        alu_a_sel    = 1'b0;
        alu_b_sel    = 1'b0;
        reg_we       = 1'b0;
        wb_sel       = WB_ALU;
        retire       = 1'b0;
        trap         = 1'b0;
        case (state_q)
            FETCH: begin
                mem_req = 1'b1;
                ir_we   = bus.mem_ready;
                if (bus.mem_ready) begin
                    state_d = DECODE;
                end
            end
            DECODE: begin
                if (bus.invalid || !is_supported(bus.opcode)) begin
                    state_d = TRAP;
                end else begin
                    state_d = EXEC;
                end
            end
            EXEC: begin
                alu_a_sel = (bus.opcode == OPC_AUIPC);
                alu_b_sel = !((bus.opcode == OPC_OP) || (bus.opcode == OPC_BRANCH));
                state_d   = (is_ld || is_st) ? MEM : WB;
            end
            MEM: begin
                mem_req      = 1'b1;
                mem_addr_sel = 1'b1;
                mem_we       = is_st;
                alu_b_sel    = 1'b1;
                if (bus.mem_ready) begin
                    if (is_st) begin
                        retire  = 1'b1;
                        pc_we   = 1'b1;
                        state_d = FETCH;
                    end else begin
                        state_d = WB;
                    end
                end
            end
            WB: begin
                wb_sel = wb_sel_of(bus.opcode);
                if (misaligned) begin
                    state_d = TRAP;
                end else begin
                    reg_we  = writes_rd(bus.opcode);
                    retire  = 1'b1;
                    pc_we   = 1'b1;
                    state_d = FETCH;
                end
            end
            TRAP: begin
                trap = 1'b1;
            end
            default: begin
                state_d = TRAP;
            end
        endcase
    end

    assign bus.mem_req      = mem_req;
    assign bus.mem_we       = mem_we;
    assign bus.mem_addr_sel = mem_addr_sel;
    assign bus.ir_we        = ir_we;
    assign bus.alu_a_sel    = alu_a_sel;
    assign bus.alu_b_sel    = alu_b_sel;
    assign bus.reg_we       = reg_we;
    assign bus.wb_sel       = wb_sel;
    assign bus.pc           = pc_q;
    assign bus.retire       = retire;
    assign bus.trap         = trap;
    assign bus.state        = state_q;

endmodule

// File: tb/tb_core_ctrl.sv
// Self-checking bench for core_ctrl: a hand-derived instruction table,
// corner-case sequences (traps, reset during a memory wait) and random
// instructions compared against an instruction-level reference model.
module tb_core_ctrl;
    import core_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    core_ctrl_if bus ();

    core_ctrl #(.RESET_PC(32'h0000_0000)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [4:0]  opcode;
        logic        invalid;
        logic [31:0] imm;
        logic [31:0] alu_res;
        logic        br_taken;
        int          fw;
        int          mw;
    } insn_t;

    typedef struct {
        int          cycles;
        logic        trap;
        logic [31:0] pc;
        logic        reg_we;
        logic [1:0]  wb_sel;
        logic        we_seen;
        logic        a_sel;
        logic        b_sel;
        int          retires;
    } result_t;

    typedef struct {
        insn_t   insn;
        result_t exp;
    } vector_t;

    vector_t tbl[15];

    // Compare one observed value against the bench's expectation
    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    function automatic vector_t mk(input logic [4:0] op, input logic inv, input logic [31:0] imm,
                                   input logic [31:0] alu, input logic br, input int fw, input int mw,
                                   input int cyc, input logic trp, input logic [31:0] pc,
                                   input logic rw, input logic [1:0] wb, input logic we,
                                   input logic a, input logic b);
        vector_t v;
        v.insn = '{opcode: op, invalid: inv, imm: imm, alu_res: alu, br_taken: br, fw: fw, mw: mw};
        v.exp  = '{cycles: cyc, trap: trp, pc: pc, reg_we: rw, wb_sel: wb, we_seen: we,
                   a_sel: a, b_sel: b, retires: (trp ? 0 : 1)};
        return v;
    endfunction

    // Instruction-level reference model: cycle count and architectural effect
    function automatic result_t predict(input insn_t i, input logic [31:0] pc);
        result_t     e;
        logic [31:0] tgt;
        logic        redirected;
        logic [4:0]  op;
        op = i.opcode;
        e  = '{cycles: 2 + i.fw, trap: 1'b0, pc: pc, reg_we: 1'b0, wb_sel: 2'd0,
               we_seen: 1'b0, a_sel: 1'b0, b_sel: 1'b0, retires: 0};
        if (i.invalid || !(op inside {OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH,
                                      OPC_LOAD, OPC_STORE, OPC_OP, OPC_OPIMM, OPC_FENCE})) begin
            e.trap = 1'b1;
            return e;
        end
        e.a_sel  = (op == OPC_AUIPC);
        e.b_sel  = !(op == OPC_OP || op == OPC_BRANCH);
        e.cycles = e.cycles + 1;
        if (op == OPC_LOAD || op == OPC_STORE) e.cycles = e.cycles + 1 + i.mw;
        if (op != OPC_STORE) e.cycles = e.cycles + 1;
        redirected = 1'b0;
        tgt        = pc + 32'd4;
        if (op == OPC_JAL) begin
            tgt = pc + i.imm; redirected = 1'b1;
        end else if (op == OPC_JALR) begin
            tgt = {i.alu_res[31:1], 1'b0}; redirected = 1'b1;
        end else if (op == OPC_BRANCH && i.br_taken) begin
            tgt = pc + i.imm; redirected = 1'b1;
        end
        if (redirected && tgt[1]) begin
            e.trap = 1'b1;
            return e;
        end
        e.pc      = tgt;
        e.retires = 1;
        e.we_seen = (op == OPC_STORE);
        e.reg_we  = op inside {OPC_LUI, OPC_AUIPC, OPC_OP, OPC_OPIMM, OPC_LOAD, OPC_JAL, OPC_JALR};
        e.wb_sel  = (op == OPC_LUI) ? 2'd3 : (op == OPC_LOAD) ? 2'd1 :
                    (op == OPC_JAL || op == OPC_JALR) ? 2'd2 : 2'd0;
        return e;
    endfunction

    // Play one instruction through the DUT acting as decoder, datapath and memory
    task automatic apply_stimulus(input insn_t i, output result_t r);
        int fcnt;
        int mcnt;
        bit done;
        r = '{cycles: 0, trap: 1'b0, pc: 32'h0, reg_we: 1'b0, wb_sel: 2'd0,
              we_seen: 1'b0, a_sel: 1'b0, b_sel: 1'b0, retires: 0};
        bus.opcode   = i.opcode;
        bus.invalid  = i.invalid;
        bus.imm      = i.imm;
        bus.alu_res  = i.alu_res;
        bus.br_taken = i.br_taken;
        fcnt = 0;
        mcnt = 0;
        done = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if (bus.mem_req) begin
                if (!bus.mem_addr_sel) begin
                    bus.mem_ready = (fcnt >= i.fw);
                    fcnt++;
                end else begin
                    bus.mem_ready = (mcnt >= i.mw);
                    mcnt++;
                end
            end else begin
                bus.mem_ready = 1'($urandom_range(0, 1));
            end
            #1;
            if (bus.trap) begin
                r.trap = 1'b1;
                done   = 1'b1;
                break;
            end
            r.cycles++;
            if (bus.state == EXEC) begin
                r.a_sel = bus.alu_a_sel;
                r.b_sel = bus.alu_b_sel;
            end
            if (bus.mem_we) r.we_seen = 1'b1;
            if (bus.reg_we) r.reg_we = 1'b1;
            if (bus.retire) begin
                r.retires++;
                r.wb_sel = bus.wb_sel;
                done     = 1'b1;
            end
            @(negedge clk);
            if (done) break;
        end
        if (!done) r.cycles = -1;
        r.pc = bus.pc;
    endtask

    task automatic compare_result(input string tag, input result_t a, input result_t e);
        check_output({tag, ".cycles"}, a.cycles, e.cycles);
        check_output({tag, ".trap"}, a.trap, e.trap);
        check_output({tag, ".pc"}, a.pc, e.pc);
        check_output({tag, ".reg_we"}, a.reg_we, e.reg_we);
        check_output({tag, ".mem_we"}, a.we_seen, e.we_seen);
        check_output({tag, ".retires"}, a.retires, e.retires);
        check_output({tag, ".alu_a_sel"}, a.a_sel, e.a_sel);
        check_output({tag, ".alu_b_sel"}, a.b_sel, e.b_sel);
        if (e.reg_we) check_output({tag, ".wb_sel"}, a.wb_sel, e.wb_sel);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n         = 1'b0;
        bus.mem_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Check that a halted core issues no memory requests and stays halted
    task automatic check_trap_hold(input string tag);
        int req_cnt;
        int notrap_cnt;
        req_cnt    = 0;
        notrap_cnt = 0;
        for (int k = 0; k < 6; k++) begin
            bus.mem_ready = 1'b1;
            #1;
            if (bus.mem_req) req_cnt++;
            if (!bus.trap || bus.retire || bus.reg_we) notrap_cnt++;
            @(negedge clk);
        end
        check_output({tag, ".hold_mem_req"}, req_cnt, 0);
        check_output({tag, ".hold_trap"}, notrap_cnt, 0);
        check_output({tag, ".hold_state"}, bus.state, TRAP);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        insn_t       ins;
        result_t     res;
        result_t     exp_r;
        logic [31:0] pc_model;
        logic [4:0]  ops[10];
        int          mem_cycles;
        bit          seen_retire;
        bit          reached;

        bus.opcode    = 5'd0;
        bus.invalid   = 1'b0;
        bus.imm       = 32'd0;
        bus.alu_res   = 32'd0;
        bus.br_taken  = 1'b0;
        bus.mem_ready = 1'b0;

        // Hand-derived sequence starting from pc=0
        tbl[0]  = mk(OPC_OPIMM,  0, 32'h5,         32'h0,         0, 0, 0,  4, 0, 32'h4,         1, 2'd0, 0, 0, 1);
        tbl[1]  = mk(OPC_LOAD,   0, 32'h10,        32'h1000,      0, 3, 3, 11, 0, 32'h8,         1, 2'd1, 0, 0, 1);
        tbl[2]  = mk(OPC_STORE,  0, 32'h4,         32'h1004,      0, 0, 1,  5, 0, 32'hC,         0, 2'd0, 1, 0, 1);
        tbl[3]  = mk(OPC_LUI,    0, 32'h1234_5000, 32'h0,         0, 1, 0,  5, 0, 32'h10,        1, 2'd3, 0, 0, 1);
        tbl[4]  = mk(OPC_AUIPC,  0, 32'h1000,      32'h0,         0, 0, 0,  4, 0, 32'h14,        1, 2'd0, 0, 1, 1);
        tbl[5]  = mk(OPC_OP,     0, 32'h0,         32'h0,         0, 2, 0,  6, 0, 32'h18,        1, 2'd0, 0, 0, 0);
        tbl[6]  = mk(OPC_JAL,    0, 32'hE8,        32'h0,         0, 0, 0,  4, 0, 32'h100,       1, 2'd2, 0, 0, 1);
        tbl[7]  = mk(OPC_BRANCH, 0, 32'hFFFF_FFF8, 32'h0,         1, 0, 0,  4, 0, 32'hF8,        0, 2'd0, 0, 0, 0);
        tbl[8]  = mk(OPC_JAL,    0, 32'h8,         32'h0,         0, 0, 0,  4, 0, 32'h100,       1, 2'd2, 0, 0, 1);
        tbl[9]  = mk(OPC_BRANCH, 0, 32'hFFFF_FFF8, 32'h0,         0, 0, 0,  4, 0, 32'h104,       0, 2'd0, 0, 0, 0);
        tbl[10] = mk(OPC_FENCE,  0, 32'h0,         32'h0,         0, 0, 0,  4, 0, 32'h108,       0, 2'd0, 0, 0, 1);
        tbl[11] = mk(OPC_JALR,   0, 32'h5,         32'h205,       0, 0, 0,  4, 0, 32'h204,       1, 2'd2, 0, 0, 1);
        tbl[12] = mk(OPC_JALR,   0, 32'h0,         32'hFFFF_FFFD, 0, 0, 0,  4, 0, 32'hFFFF_FFFC, 1, 2'd2, 0, 0, 1);
        tbl[13] = mk(OPC_OPIMM,  0, 32'h1,         32'h0,         0, 0, 0,  4, 0, 32'h0,         1, 2'd0, 0, 0, 1);
        tbl[14] = mk(OPC_BRANCH, 0, 32'h6,         32'h0,         1, 0, 0,  4, 1, 32'h0,         0, 2'd0, 0, 0, 0);

        ops = '{OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH,
                OPC_LOAD, OPC_STORE, OPC_OP, OPC_OPIMM, OPC_FENCE};

        // Reset state
        do_reset();
        #1;
        check_output("reset.state", bus.state, FETCH);
        check_output("reset.pc", bus.pc, 32'h0);
        check_output("reset.mem_req", bus.mem_req, 1'b1);
        check_output("reset.mem_addr_sel", bus.mem_addr_sel, 1'b0);
        check_output("reset.mem_we", bus.mem_we, 1'b0);
        check_output("reset.trap", bus.trap, 1'b0);
        check_output("reset.retire", bus.retire, 1'b0);
        check_output("reset.reg_we", bus.reg_we, 1'b0);
        check_output("reset.ir_we", bus.ir_we, 1'b0);

        // Table-driven sequence
        for (int v = 0; v < 15; v++) begin
            apply_stimulus(tbl[v].insn, res);
            compare_result($sformatf("tbl%0d", v), res, tbl[v].exp);
        end
        check_trap_hold("tbl_branch_misaligned");

        // JAL to pc+6 from reset: trap, no retire, pc unchanged
        do_reset();
        ins = '{opcode: OPC_JAL, invalid: 1'b0, imm: 32'h6, alu_res: 32'h0, br_taken: 1'b0, fw: 0, mw: 0};
        apply_stimulus(ins, res);
        compare_result("jal_misaligned", res, predict(ins, 32'h0));
        check_output("jal_misaligned.trap_flag", res.trap, 1'b1);
        check_trap_hold("jal_misaligned");

        // Decoder-flagged invalid instruction
        do_reset();
        ins = '{opcode: OPC_OPIMM, invalid: 1'b1, imm: 32'h0, alu_res: 32'h0, br_taken: 1'b0, fw: 1, mw: 0};
        apply_stimulus(ins, res);
        compare_result("invalid_flag", res, predict(ins, 32'h0));
        check_trap_hold("invalid_flag");

        // Unsupported opcode 11100
        do_reset();
        ins = '{opcode: 5'b11100, invalid: 1'b0, imm: 32'h0, alu_res: 32'h0, br_taken: 1'b0, fw: 0, mw: 0};
        apply_stimulus(ins, res);
        compare_result("bad_opcode", res, predict(ins, 32'h0));
        check_trap_hold("bad_opcode");

        // Reset asserted in the middle of a LOAD memory wait
        do_reset();
        ins = '{opcode: OPC_OPIMM, invalid: 1'b0, imm: 32'h0, alu_res: 32'h0, br_taken: 1'b0, fw: 0, mw: 0};
        apply_stimulus(ins, res);
        compare_result("pre_abort", res, predict(ins, 32'h0));
        bus.opcode   = OPC_LOAD;
        bus.invalid  = 1'b0;
        bus.alu_res  = 32'h2000;
        mem_cycles   = 0;
        seen_retire  = 1'b0;
        reached      = 1'b0;
        for (int k = 0; k < 20; k++) begin
            bus.mem_ready = bus.mem_req && !bus.mem_addr_sel;
            #1;
            if (bus.retire) seen_retire = 1'b1;
            if (bus.state == MEM) begin
                mem_cycles++;
                if (mem_cycles == 3) begin
                    reached = 1'b1;
                    break;
                end
            end
            @(negedge clk);
        end
        check_output("abort.reached_mem_wait", reached, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check_output("abort.state", bus.state, FETCH);
        check_output("abort.pc", bus.pc, 32'h0);
        check_output("abort.mem_req", bus.mem_req, 1'b1);
        check_output("abort.mem_addr_sel", bus.mem_addr_sel, 1'b0);
        check_output("abort.trap", bus.trap, 1'b0);
        check_output("abort.retire", bus.retire | seen_retire, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized instructions against the reference model
        do_reset();
        pc_model = 32'h0;
        for (int n = 0; n < 200; n++) begin
            ins.opcode   = ops[$urandom_range(0, 9)];
            ins.invalid  = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 19) == 0) ins.opcode = 5'b11100;
            ins.imm      = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 9) == 0) ins.imm = ins.imm | 32'h2;
            ins.alu_res  = $urandom & 32'hFFFF_FFFD;
            if ($urandom_range(0, 9) == 0) ins.alu_res = ins.alu_res | 32'h2;
            ins.br_taken = 1'($urandom_range(0, 1));
            ins.fw       = $urandom_range(0, 2);
            ins.mw       = $urandom_range(0, 2);
            exp_r = predict(ins, pc_model);
            apply_stimulus(ins, res);
            compare_result($sformatf("rand%0d", n), res, exp_r);
            if (exp_r.trap || res.trap) begin
                do_reset();
                pc_model = 32'h0;
            end else begin
                pc_model = exp_r.pc;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
